// File: rtl/misc_memory_dp.sv
// misc_memory_dp: dual-port synchronous memory for the MISC-V core.
// Port I is read-only (instruction fetch). Port D is read/write with byte enables.
// The read latency is READ_PIPE cycles, either 1 or 2.
// Optional macro MEM_CLEAR_EN: after reset release, zero every word before raising ready.
module misc_memory_dp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int READ_PIPE  = 1,
    parameter     INIT_FILE  = ""
) (
    input  logic                      clk,
    input  logic                      reset_n,
    output logic                      ready,
    input  logic                      i_req,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    output logic                      i_valid,
    output logic [DATA_WIDTH-1:0]     i_rdata,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [DATA_WIDTH/8-1:0]   d_be,
    input  logic [ADDR_WIDTH-1:0]     d_addr,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    output logic                      d_valid,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic                      collision
);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_ready;

    logic w_i_acc, w_d_wr, w_d_rd, w_col;
    assign w_i_acc = i_req & r_ready;
    assign w_d_wr  = d_req & r_ready & d_we;
    assign w_d_rd  = d_req & r_ready & ~d_we;
    // The I-read sees the old word (read-first), so flag the overlap for software.
    assign w_col   = w_i_acc & w_d_wr & (i_addr == d_addr);
    assign ready   = r_ready;

`ifdef MEM_CLEAR_EN
    typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_clr_addr;

    // Sequence RESET -> CLEAR -> READY. The sweep zeroes one word per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_RESET;
            r_ready    <= 1'b0;
            r_clr_addr <= '0;
        end else begin
            case (r_state)
                ST_RESET: begin
                    r_state    <= ST_CLEAR;
                    r_clr_addr <= '0;
                end
                ST_CLEAR: begin
                    r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
                    if (r_clr_addr == '1) begin
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                    end
                end
                default: r_ready <= 1'b1;
            endcase
        end
    end
`else
    typedef enum logic {ST_RESET, ST_READY} state_t;
    state_t r_state;

    // Sequence RESET -> READY. Requests are accepted from the second edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RESET;
            r_ready <= 1'b0;
        end else begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
        end
    end
`endif

    // Memory array: the clear sweep has priority; otherwise a byte-masked D-port write.
    // No reset here, so the contents survive reset.
    always_ff @(posedge clk) begin
`ifdef MEM_CLEAR_EN
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_addr] <= '0;
        end else
`endif
        if (w_d_wr) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (d_be[k]) r_mem[d_addr][8*k +: 8] <= d_wdata[8*k +: 8];
            end
        end
    end

    logic                  r_i_v1, r_d_v1, r_col1;
    logic [DATA_WIDTH-1:0] r_i_q1, r_d_q1;

    // First read stage: capture the array word on acceptance. Data holds between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i_v1 <= 1'b0;
            r_d_v1 <= 1'b0;
            r_col1 <= 1'b0;
            r_i_q1 <= '0;
            r_d_q1 <= '0;
        end else begin
            r_i_v1 <= w_i_acc;
            r_d_v1 <= w_d_rd;
            r_col1 <= w_col;
            if (w_i_acc) r_i_q1 <= r_mem[i_addr];
            if (w_d_rd)  r_d_q1 <= r_mem[d_addr];
        end
    end

    if (READ_PIPE == 2) begin : g_pipe2
        logic                  r_i_v2, r_d_v2, r_col2;
        logic [DATA_WIDTH-1:0] r_i_q2, r_d_q2;

        // Extra output register stage. Data loads only on a valid beat.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_i_v2 <= 1'b0;
                r_d_v2 <= 1'b0;
                r_col2 <= 1'b0;
                r_i_q2 <= '0;
                r_d_q2 <= '0;
            end else begin
                r_i_v2 <= r_i_v1;
                r_d_v2 <= r_d_v1;
                r_col2 <= r_col1;
                if (r_i_v1) r_i_q2 <= r_i_q1;
                if (r_d_v1) r_d_q2 <= r_d_q1;
            end
        end

        assign i_valid   = r_i_v2;
        assign i_rdata   = r_i_q2;
        assign d_valid   = r_d_v2;
        assign d_rdata   = r_d_q2;
        assign collision = r_col2;
    end else begin : g_pipe1
        assign i_valid   = r_i_v1;
        assign i_rdata   = r_i_q1;
        assign d_valid   = r_d_v1;
        assign d_rdata   = r_d_q1;
        assign collision = r_col1;
    end

endmodule

// File: tb/tb_misc_memory_dp.sv
// tb_misc_memory_dp: runs a READ_PIPE=1 and a READ_PIPE=2 instance side by side.
// Both instances get the same stimulus.
// A reference model (array + per-edge event history) predicts every output each cycle.
// Define MEM_CLEAR_EN to cover the clear-sweep build.
module tb_misc_memory_dp;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;
`ifdef MEM_CLEAR_EN
    localparam int READY_EDGES = DEPTH + 1;
    localparam bit CLR = 1'b1;
`else
    localparam int READY_EDGES = 1;
    localparam bit CLR = 1'b0;
`endif

    logic clk, reset_n;
    logic i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [NB-1:0] d_be;
    logic [DW-1:0] d_wdata;
    logic [2:1] ready_w, i_valid_w, d_valid_w, col_w;
    logic [2:1][DW-1:0] i_rdata_w, d_rdata_w;

    misc_memory_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PIPE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .ready(ready_w[1]),
        .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid_w[1]), .i_rdata(i_rdata_w[1]),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid_w[1]), .d_rdata(d_rdata_w[1]), .collision(col_w[1]));

    misc_memory_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PIPE(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .ready(ready_w[2]),
        .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid_w[2]), .i_rdata(i_rdata_w[2]),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid_w[2]), .d_rdata(d_rdata_w[2]), .collision(col_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read result produced at one accepting edge; it shows up L edges later.
    typedef struct packed {
        bit          iv;
        bit [DW-1:0] id;
        bit          col;
        bit          dv;
        bit [DW-1:0] dd;
    } ev_t;

    logic [DW-1:0] m_mem [DEPTH];
    bit            m_ready;
    int            rel_edges;
    int            n;
    ev_t           hist [8];
    logic [DW-1:0] hold_i [2:1];
    logic [DW-1:0] hold_d [2:1];
    int            checks, errors;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_reset(input bit v);
        reset_n = v;
        if (!v) begin
            rel_edges = 0;
            m_ready   = 1'b0;
            for (int k = 0; k < 8; k++) hist[k] = '0;
            for (int l = 1; l <= 2; l++) begin
                hold_i[l] = '0;
                hold_d[l] = '0;
            end
        end
    endtask

    // Apply one clock edge to the model and the DUTs, then compare every output.
    task automatic step();
        ev_t e;
        e = '0;
        if (reset_n) begin
            if (m_ready) begin
                if (i_req) begin
                    e.iv  = 1'b1;
                    e.id  = m_mem[i_addr];
                    e.col = d_req && d_we && (d_addr == i_addr);
                end
                if (d_req && !d_we) begin
                    e.dv = 1'b1;
                    e.dd = m_mem[d_addr];
                end
                if (d_req && d_we)
                    for (int k = 0; k < NB; k++)
                        if (d_be[k]) m_mem[d_addr][8*k +: 8] = d_wdata[8*k +: 8];
            end
            rel_edges++;
        end
        n++;
        hist[n % 8] = e;
        @(posedge clk);
        #1;
        if (CLR && reset_n && rel_edges == READY_EDGES)
            for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
        m_ready = reset_n && (rel_edges >= READY_EDGES);
        for (int l = 1; l <= 2; l++) begin
            ev_t x;
            x = hist[(n - l + 1) % 8];
            if (x.iv) hold_i[l] = x.id;
            if (x.dv) hold_d[l] = x.dd;
            chk($sformatf("ready%0d", l),   16'(ready_w[l]),   16'(m_ready));
            chk($sformatf("i_valid%0d", l), 16'(i_valid_w[l]), 16'(x.iv));
            chk($sformatf("i_rdata%0d", l), i_rdata_w[l],      hold_i[l]);
            chk($sformatf("col%0d", l),     16'(col_w[l]),     16'(x.col));
            chk($sformatf("d_valid%0d", l), 16'(d_valid_w[l]), 16'(x.dv));
            chk($sformatf("d_rdata%0d", l), d_rdata_w[l],      hold_d[l]);
        end
    endtask

    task automatic drv(input bit ir, input int ia, input bit dr, input bit dw,
                       input int be, input int da, input int wd);
        i_req   = ir;
        i_addr  = AW'(ia);
        d_req   = dr;
        d_we    = dw;
        d_be    = NB'(be);
        d_addr  = AW'(da);
        d_wdata = DW'(wd);
        step();
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_step();
        drv($urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, (1 << NB) - 1), $urandom_range(0, DEPTH - 1),
            $urandom_range(0, 16'hFFFF));
    endtask

    task automatic wait_ready(input string tag);
        for (int t = 0; t < 200 && !m_ready; t++) rand_step();
        chk(tag, 16'(ready_w[1] & ready_w[2]), 16'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        for (int l = 1; l <= 2; l++) begin
            chk($sformatf("%s_ready%0d", tag, l), 16'(ready_w[l]), 16'd0);
            chk($sformatf("%s_iv%0d", tag, l),    16'(i_valid_w[l]), 16'd0);
            chk($sformatf("%s_dv%0d", tag, l),    16'(d_valid_w[l]), 16'd0);
            chk($sformatf("%s_col%0d", tag, l),   16'(col_w[l]), 16'd0);
            chk($sformatf("%s_ird%0d", tag, l),   i_rdata_w[l], 16'd0);
            chk($sformatf("%s_drd%0d", tag, l),   d_rdata_w[l], 16'd0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n      = 8;
        for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
        set_reset(1'b0);
        repeat (3) step();
        chk_all_zero("rst");

        // Release. Random requests while not ready must be ignored.
        set_reset(1'b1);
`ifdef MEM_CLEAR_EN
        repeat (8) rand_step();
        set_reset(1'b0);
        step();
        set_reset(1'b1);
        repeat (16) rand_step();
        chk("sweep_ready_low", 16'(ready_w[1]), 16'd0);
        rand_step();
        chk("sweep_ready_high", 16'(ready_w[1]), 16'd1);
        // Every word reads back as zero after the sweep.
        for (int a = 0; a < DEPTH; a++) drv(1, a, 1, 0, 0, DEPTH - 1 - a, 0);
        idle();
        chk("clr_zero", i_rdata_w[2], 16'd0);
`endif
        wait_ready("ready_up");

        // Give every word a known value.
        for (int a = 0; a < DEPTH; a++) drv(0, 0, 1, 1, 3, a, $urandom_range(0, 16'hFFFF));

        // Byte-enable merge.
        drv(0, 0, 1, 1, 3, 3, 'h1234);
        drv(0, 0, 1, 1, 2, 3, 'hAB00);
        drv(0, 0, 1, 0, 0, 3, 0);
        chk("be_merge1", d_rdata_w[1], 16'hAB34);
        drv(0, 0, 1, 1, 0, 3, 'hFFFF);
        chk("be_merge2", d_rdata_w[2], 16'hAB34);

        // Read-first collision, then the new data with no collision.
        drv(0, 0, 1, 1, 3, 7, 'h1111);
        drv(1, 7, 1, 1, 3, 7, 'h2222);
        chk("col_old1", i_rdata_w[1], 16'h1111);
        chk("col_pulse1", 16'(col_w[1]), 16'd1);
        drv(1, 7, 1, 0, 0, 7, 0);
        chk("col_old2", i_rdata_w[2], 16'h1111);
        chk("col_new1", i_rdata_w[1], 16'h2222);
        chk("col_none1", 16'(col_w[1]), 16'd0);
        idle();
        chk("col_new2", i_rdata_w[2], 16'h2222);
        chk("dd_same2", d_rdata_w[2], 16'h2222);

        // Back-to-back D reads of words 0, 1, 2, then data hold.
        drv(0, 0, 1, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 1, 0);
        drv(0, 0, 1, 0, 0, 2, 0);
        repeat (3) idle();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                set_reset(1'b0);
                step();
                step();
                set_reset(1'b1);
            end
            rand_step();
        end

        // Reset one cycle after an accepted read drops the in-flight result.
        wait_ready("ready_up2");
        drv(1, 5, 1, 0, 0, 6, 0);
        set_reset(1'b0);
        #1;
        chk_all_zero("midrst");
        idle();
        idle();
        set_reset(1'b1);
        for (int t = 0; t < READY_EDGES + 3; t++) idle();
        chk("post_rst_iv", 16'(i_valid_w[2]), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
